pixel_line_summer: RTL

PIXEL_LINE_SUMMER -- requirements
Module: pixel_line_summer

---
 rtl/pixel_line_summer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pixel_line_summer.sv
// pixel_line_summer
//   Streams unsigned pixel pairs, multiplies each pair and sums the products
//   over one line of LINE_SIZE pairs. Completed line sums are handed out on a
//   valid/ready port together with a flag that marks the last line of a frame.
//   Accumulation of the next line continues while a result is held, and stalls
//   only on the final pair of a line when the held result has not been taken.
//
// Ports
//   CLK         sole clock, rising edge
//   reset       synchronous, active-high
//   pix_valid   pixel pair present on pixel_a/pixel_b
//   pix_ready   pair accepted when pix_valid && pix_ready
//   pixel_a     first operand, unsigned, PIXEL_SIZE bits
//   pixel_b     second operand, unsigned, PIXEL_SIZE bits
//   line_sum    completed line sum of products
//   line_valid  line_sum holds a completed line
//   line_ready  downstream takes line_sum when line_valid && line_ready
//   frame_last  presented line is the last line of its frame
module pixel_line_summer #(
  parameter int PIXEL_SIZE   = 8,
  parameter int LINE_SIZE    = 640,
  parameter int NUM_OF_LINES = 480
) (
  input  logic                                        CLK,
  input  logic                                        reset,
  input  logic                                        pix_valid,
  output logic                                        pix_ready,
  input  logic [PIXEL_SIZE-1:0]                       pixel_a,
  input  logic [PIXEL_SIZE-1:0]                       pixel_b,
  output logic [$clog2(LINE_SIZE)+2*PIXEL_SIZE-1:0]   line_sum,
  output logic                                        line_valid,
  input  logic                                        line_ready,
  output logic                                        frame_last
);

  localparam int SUM_W  = $clog2(LINE_SIZE) + 2*PIXEL_SIZE;
  localparam int PCNT_W = $clog2(LINE_SIZE);
  localparam int LCNT_W = $clog2(NUM_OF_LINES);
  localparam logic [PCNT_W-1:0] PIX_LAST  = PCNT_W'(LINE_SIZE - 1);
  localparam logic [LCNT_W-1:0] LINE_LAST = LCNT_W'(NUM_OF_LINES - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Full-precision unsigned product, zero-extended to accumulator width.
  // The accumulator is wide enough for LINE_SIZE maximal products, so no
  // saturation is ever required.
  function automatic logic [SUM_W-1:0] widen_product(
    input logic [PIXEL_SIZE-1:0] a,
    input logic [PIXEL_SIZE-1:0] b
  );
    logic [2*PIXEL_SIZE-1:0] p;
    p = {{PIXEL_SIZE{1'b0}}, a} * {{PIXEL_SIZE{1'b0}}, b};
    return SUM_W'(p);
  endfunction

  state_t              state;
  logic [PCNT_W-1:0]   pix_cnt_p0;
  logic [LCNT_W-1:0]   line_cnt_p1;
  logic [SUM_W-1:0]    acc_p0;
  logic [SUM_W-1:0]    sum_p1;
  logic                vld_p1;
  logic                last_p1;

  logic                last_pix;
  logic                accept;
  logic                complete;
  logic                take;
  logic [SUM_W-1:0]    prod;

  assign prod      = widen_product(pixel_a, pixel_b);
  assign last_pix  = (pix_cnt_p0 == PIX_LAST);
  // The only stall: closing a line while the previous result is still held.
  assign pix_ready = !(last_pix && (state == FULL) && !line_ready);
  assign accept    = pix_valid && pix_ready;
  assign complete  = accept && last_pix;
  assign take      = vld_p1 && line_ready;

  // Stage p0: per-pair accumulation
  always_ff @(posedge CLK) begin
    if (reset) begin
      pix_cnt_p0 <= '0;
      acc_p0     <= '0;
    end else if (accept) begin
      pix_cnt_p0 <= last_pix ? '0 : pix_cnt_p0 + 1'b1;
      acc_p0     <= (pix_cnt_p0 == '0) ? prod : acc_p0 + prod;
    end
  end

  // Stage p1: completed-line output register and hand-off FSM
  always_ff @(posedge CLK) begin
    if (reset) begin
      state       <= EMPTY;
      vld_p1      <= 1'b0;
      sum_p1      <= '0;
      last_p1     <= 1'b0;
      line_cnt_p1 <= '0;
    end else begin
      if (complete) begin
        sum_p1      <= acc_p0 + prod;
        last_p1     <= (line_cnt_p1 == LINE_LAST);
        line_cnt_p1 <= (line_cnt_p1 == LINE_LAST) ? '0 : line_cnt_p1 + 1'b1;
      end
      case (state)
        EMPTY: begin
          if (complete) begin
            state  <= FULL;
            vld_p1 <= 1'b1;
          end
        end
        FULL: begin
          // A completion while FULL implies line_ready is high, so the held
          // line is consumed in the same cycle the new one is loaded.
          if (!complete && take) begin
            state  <= EMPTY;
            vld_p1 <= 1'b0;
          end
        end
        default: begin
          state  <= EMPTY;
          vld_p1 <= 1'b0;
        end
      endcase
    end
  end

  assign line_sum   = sum_p1;
  assign line_valid = vld_p1;
  assign frame_last = last_p1;

endmodule
